phy_tx_mux: RTL

PHY_TX_MUX -- requirements
Module: phy_tx_mux

---
 rtl/phy_pkg.sv | 15 +
 rtl/phy_lane_fifo.sv | 72 +++++++
 rtl/phy_tx_mux.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/phy_pkg.sv
// Shared constants and state type for the PHY transmit multiplexer.
package phy_pkg;

    // Comma symbol placed in every header slot.
    localparam logic [7:0] COM  = 8'hBC;
    // Filler symbol sent in a lane slot whose FIFO was empty at load time.
    localparam logic [7:0] IDLE = 8'h7C;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_HDR  = 2'd1,
        ST_LANE = 2'd2
    } state_t;

endpackage

// File: rtl/phy_lane_fifo.sv
// Per-lane word FIFO. The head word is visible combinationally so the
// serializer can load it on the same edge it pops.
module phy_lane_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk16,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_FULL);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers (wrap naturally, depth is a power of two) and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Register FIFO state; reset empties the FIFO.
    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/phy_tx_mux.sv
// Multi-lane PHY transmit multiplexer: serializes a header slot followed by
// one slot per lane, MSB first, one bit per clk16 edge.
// Optional build macro PHY_TX_PARITY_EN appends an even-parity bit to each slot.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_OFF  | idle, ser_out held low, no FIFO pops
// ST_HDR  | shifting the header slot {0, COM}
// ST_LANE | shifting a lane slot {1, word} or {0, IDLE}
module phy_tx_mux
    import phy_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk16,
    input  logic                        reset,
    input  logic                        tx_en,
    input  logic [NUM_LANES-1:0]        in_valid,
    input  logic [NUM_LANES*DATA_W-1:0] in_data,
    output logic [NUM_LANES-1:0]        in_ready,
    output logic                        ser_out,
    output logic                        frame_start
);

`ifdef PHY_TX_PARITY_EN
    localparam int SLOT_LEN = DATA_W + 2;
`else
    localparam int SLOT_LEN = DATA_W + 1;
`endif
    localparam int BIT_W      = $clog2(SLOT_LEN);
    localparam int SLOT_CNT_W = $clog2(NUM_LANES + 1);

    localparam logic [BIT_W-1:0]      BIT_LAST  = BIT_W'(SLOT_LEN - 1);
    localparam logic [SLOT_CNT_W-1:0] SLOT_LAST = SLOT_CNT_W'(NUM_LANES);
    localparam logic [DATA_W-1:0]     COM_W     = DATA_W'(COM);
    localparam logic [DATA_W-1:0]     IDLE_W    = DATA_W'(IDLE);

    state_t                  state_q, state_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [SLOT_CNT_W-1:0]   slot_q, slot_d;
    logic [SLOT_LEN-1:0]     shift_q, shift_d;
    logic                    frame_start_q, frame_start_d;

    logic                    load;
    logic [SLOT_CNT_W-1:0]   next_slot;
    logic [DATA_W:0]         slot_word;

    logic [NUM_LANES-1:0]    fifo_pop;
    logic [NUM_LANES-1:0]    fifo_empty;
    logic [NUM_LANES-1:0]    fifo_full;
    logic [DATA_W-1:0]       fifo_head [NUM_LANES];

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            phy_lane_fifo #(
                .DATA_W     (DATA_W),
                .FIFO_DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk16     (clk16),
                .reset     (reset),
                .push      (in_valid[g]),
                .push_data (in_data[g*DATA_W +: DATA_W]),
                .pop       (fifo_pop[g]),
                .head_data (fifo_head[g]),
                .empty     (fifo_empty[g]),
                .full      (fifo_full[g])
            );
        end
    endgenerate

    assign in_ready    = ~fifo_full;
    assign ser_out     = shift_q[SLOT_LEN-1];
    assign frame_start = frame_start_q;

    // Sequencing: decide when a new slot loads, which slot it is, and pop its lane FIFO.
    always_comb begin
        state_d       = state_q;
        bit_d         = bit_q;
        slot_d        = slot_q;
        shift_d       = {shift_q[SLOT_LEN-2:0], 1'b0};
        frame_start_d = 1'b0;
        fifo_pop      = '0;
        load          = 1'b0;
        next_slot     = '0;
        slot_word     = '0;

        case (state_q)
            ST_OFF: begin
                shift_d = '0;
                if (tx_en) begin
                    load = 1'b1;
                end
            end
            default: begin
                if (bit_q == BIT_LAST) begin
                    if (slot_q == SLOT_LAST) begin
                        if (tx_en) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_OFF;
                            bit_d   = '0;
                            slot_d  = '0;
                            shift_d = '0;
                        end
                    end else begin
                        load      = 1'b1;
                        next_slot = slot_q + 1'b1;
                    end
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
        endcase

        if (load) begin
            bit_d  = '0;
            slot_d = next_slot;
            if (next_slot == '0) begin
                state_d       = ST_HDR;
                slot_word     = {1'b0, COM_W};
                frame_start_d = 1'b1;
            end else begin
                state_d   = ST_LANE;
                slot_word = {1'b0, IDLE_W};
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (next_slot == SLOT_CNT_W'(i + 1) && !fifo_empty[i]) begin
                        fifo_pop[i] = 1'b1;
                        slot_word   = {1'b1, fifo_head[i]};
                    end
                end
            end
`ifdef PHY_TX_PARITY_EN
            shift_d = {slot_word, ^slot_word};
`else
            shift_d = slot_word;
`endif
        end
    end

    // Single state register for the FSM, counters and registered outputs.
    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) begin
            state_q       <= ST_OFF;
            bit_q         <= '0;
            slot_q        <= '0;
            shift_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_q         <= bit_d;
            slot_q        <= slot_d;
            shift_q       <= shift_d;
            frame_start_q <= frame_start_d;
        end
    end

endmodule
